// File: rtl/coin_credit_acc.sv
// Coin credit accumulator feeding the vending-machine FSM.
// Turns coin strobes into a running credit and drives the FSM's coin pulse
// and sufficient level. Settles each sale by issuing change, or a full
// refund on cancel.
module coin_credit_acc #(
  parameter int unsigned CREDIT_W   = 8,
  parameter int unsigned MAX_CREDIT = 200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_value,
  input  logic [CREDIT_W-1:0] price,
  input  logic                vend_done,
  input  logic                cancel,
  output logic                coin,
  output logic                sufficient,
  output logic [CREDIT_W-1:0] credit,
  output logic                reject,
  output logic [CREDIT_W-1:0] change,
  output logic                change_valid
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PAID    = 2'd2,
    SETTLE  = 2'd3
  } state_t;

  // One guard bit, so credit + coin can never wrap before the limit check.
  localparam logic [CREDIT_W:0] MAX_SUM = (CREDIT_W+1)'(MAX_CREDIT);

  state_t              state, state_nx;
  logic [CREDIT_W:0]   amount;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] credit_nx;
  logic [CREDIT_W-1:0] change_nx;
  logic                coin_nx;
  logic                reject_nx;

  // Decode the coin code into cents.
  always_comb begin
    amount = '0;
    unique case (coin_value)
      2'b00: amount = (CREDIT_W+1)'(5);
      2'b01: amount = (CREDIT_W+1)'(10);
      2'b10: amount = (CREDIT_W+1)'(25);
      2'b11: amount = (CREDIT_W+1)'(100);
      default: amount = '0;
    endcase
  end

  // Next-state, credit, change and pulse decisions.
  always_comb begin
    state_nx  = state;
    credit_nx = credit;
    change_nx = change;
    coin_nx   = 1'b0;
    reject_nx = 1'b0;
    sum       = {1'b0, credit} + amount;

    unique case (state)
      IDLE, COLLECT: begin
        if (state == COLLECT && cancel) begin
          // Cancel beats a simultaneous coin: the coin is bounced, not refunded.
          state_nx  = SETTLE;
          change_nx = credit;
          reject_nx = coin_valid;
        end else begin
          if (coin_valid) begin
            if (sum <= MAX_SUM) begin
              credit_nx = sum[CREDIT_W-1:0];
              coin_nx   = 1'b1;
            end else begin
              reject_nx = 1'b1;
            end
          end
          // Classify on the post-coin credit.
          if (credit_nx >= price && price != '0)
            state_nx = PAID;
          else if (credit_nx != '0)
            state_nx = COLLECT;
          else
            state_nx = IDLE;
        end
      end

      PAID: begin
        reject_nx = coin_valid;
        if (vend_done) begin
          // Sale completes even if cancel arrives on the same edge.
          state_nx  = SETTLE;
          change_nx = (credit >= price) ? (credit - price) : '0;
        end else if (cancel) begin
          state_nx  = SETTLE;
          change_nx = credit;
        end else if (price == '0 || price > credit) begin
          state_nx = COLLECT;
        end
      end

      SETTLE: begin
        reject_nx = coin_valid;
        credit_nx = '0;
        state_nx  = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

  // Register state and every output so that nothing reaches the FSM combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      credit       <= '0;
      change       <= '0;
      coin         <= 1'b0;
      reject       <= 1'b0;
      sufficient   <= 1'b0;
      change_valid <= 1'b0;
    end else begin
      state        <= state_nx;
      credit       <= credit_nx;
      change       <= change_nx;
      coin         <= coin_nx;
      reject       <= reject_nx;
      sufficient   <= (state_nx == PAID);
      change_valid <= (state_nx == SETTLE);
    end
  end

endmodule
